// File: rtl/pe_pkg.sv
// Shared widths and width helpers for the multiply-accumulate lane array.
package pe_pkg;

  localparam int DEF_LANES     = 4;
  localparam int DEF_WEIGHT_BW = 8;
  localparam int DEF_DATA_BW   = 8;
  localparam int DEF_ACC_BW    = 24;

  // Ceiling log2 for elaboration-time width math (clog2_int(1) == 0).
  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of one full-precision signed weight x data product.
  function automatic int prod_width(input int wbw, input int dbw);
    return wbw + dbw;
  endfunction

  // Width of the full-precision sum of all lane products.
  function automatic int sum_width(input int wbw, input int dbw, input int lanes);
    return wbw + dbw + clog2_int(lanes);
  endfunction

  // Lane index width; a single lane still needs a one-bit select.
  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? clog2_int(lanes) : 1;
  endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// Double-buffered weight storage: a shadow bank written lane by lane and an
// active bank updated all at once on swap. Active weights leave as a packed bus,
// lane 0 in the LSBs.
module pe_weight_bank
  import pe_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int WEIGHT_BW = DEF_WEIGHT_BW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                w_load_i,
  input  logic [lane_idx_width(LANES)-1:0]    w_lane_i,
  input  logic [WEIGHT_BW-1:0]                w_data_i,
  input  logic                                w_swap_i,
  output logic [LANES*WEIGHT_BW-1:0]          active_w_o
);

  localparam int LANE_W = lane_idx_width(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LANE_W-1:0] IDX = LANE_W'(gi);

    logic                 hit;
    logic [WEIGHT_BW-1:0] shadow_q, shadow_d;
    logic [WEIGHT_BW-1:0] active_q, active_d;

    // Out-of-range lane indices never match any lane, so they are dropped.
    assign hit = w_load_i && (w_lane_i == IDX);

    // Shadow takes a load; swap copies shadow, passing a same-cycle load straight through.
    always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (hit) shadow_d = w_data_i;
      if (w_swap_i) active_d = hit ? w_data_i : shadow_q;
    end

    // Weight registers clear on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign active_w_o[gi*WEIGHT_BW +: WEIGHT_BW] = active_q;
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// Two-stage signed dot-product accumulator over LANES weight x data lanes.
// Stage 1 registers per-lane products; stage 2 adds their sum into the
// accumulator and publishes the total on a last beat.
// Build option: define PE_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int WEIGHT_BW = DEF_WEIGHT_BW,
  parameter int DATA_BW   = DEF_DATA_BW,
  parameter int ACC_BW    = DEF_ACC_BW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             w_load,
  input  logic [lane_idx_width(LANES)-1:0] w_lane,
  input  logic [WEIGHT_BW-1:0]             w_data,
  input  logic                             w_swap,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_BW-1:0]         in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_BW-1:0]                out_acc
);

  localparam int PROD_W = prod_width(WEIGHT_BW, DATA_BW);
  localparam int SUM_W  = sum_width(WEIGHT_BW, DATA_BW, LANES);

  logic [LANES*WEIGHT_BW-1:0] active_w;
  logic [LANES*PROD_W-1:0]    prod_bus;
  logic                       stall;
  logic                       p_valid_q, p_valid_d;
  logic                       p_last_q, p_last_d;
  logic signed [SUM_W-1:0]    dot;
  logic signed [ACC_BW-1:0]   acc_q, acc_d, acc_sum;
  logic                       out_valid_q, out_valid_d;
  logic [ACC_BW-1:0]          out_acc_q, out_acc_d;

  pe_weight_bank #(
    .LANES     (LANES),
    .WEIGHT_BW (WEIGHT_BW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .w_load_i   (w_load),
    .w_lane_i   (w_lane),
    .w_data_i   (w_data),
    .w_swap_i   (w_swap),
    .active_w_o (active_w)
  );

  // A result waiting on the consumer freezes the whole pipeline.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    logic signed [WEIGHT_BW-1:0] w_s;
    logic signed [DATA_BW-1:0]   d_s;
    logic signed [PROD_W-1:0]    prod_d, prod_q;

    assign w_s    = active_w[gi*WEIGHT_BW +: WEIGHT_BW];
    assign d_s    = in_data[gi*DATA_BW +: DATA_BW];
    assign prod_d = PROD_W'(w_s) * PROD_W'(d_s);

    // Stage 1 product register; reads the active weights as they stood before this edge.
    always_ff @(posedge clk) begin
      if (rst) prod_q <= '0;
      else if (!stall) prod_q <= prod_d;
    end

    assign prod_bus[gi*PROD_W +: PROD_W] = prod_q;
  end

  // Full-precision sum of the registered products.
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + SUM_W'($signed(prod_bus[i*PROD_W +: PROD_W]));
    end
  end

`ifdef PE_MAC_SATURATE_EN
  localparam int EXT_W = ((ACC_BW > SUM_W) ? ACC_BW : SUM_W) + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({1'b0, {(ACC_BW-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - 1;
  logic signed [EXT_W-1:0] sum_ext;

  // Accumulate with clamping to the signed ACC_BW range.
  always_comb begin
    sum_ext = EXT_W'(acc_q) + EXT_W'(dot);
    if (sum_ext > SAT_MAX)      acc_sum = ACC_BW'(SAT_MAX);
    else if (sum_ext < SAT_MIN) acc_sum = ACC_BW'(SAT_MIN);
    else                        acc_sum = sum_ext[ACC_BW-1:0];
  end
`else
  // Accumulate with two's-complement wrap at ACC_BW.
  always_comb begin
    acc_sum = acc_q + ACC_BW'(dot);
  end
`endif

  // Next state for the stage valids, accumulator and result register.
  always_comb begin
    p_valid_d   = p_valid_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    if (!stall) begin
      p_valid_d   = in_valid;
      p_last_d    = in_last;
      out_valid_d = p_valid_q && p_last_q;
      if (p_valid_q) begin
        if (p_last_q) begin
          out_acc_d = acc_sum;
          acc_d     = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  // Control and accumulator registers; reset drops partial sums and in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;

endmodule

// File: tb/tb_pe_mac_lanes.sv
// Scoreboard bench for pe_mac_lanes: a default-width instance and an ACC_BW=16
// instance share one stimulus stream; a monitor pops expected results on each
// output handshake. Honours PE_MAC_SATURATE_EN for the overflow expectation.
module tb_pe_mac_lanes;

  logic        clk = 1'b0;
  logic        rst, w_load, w_swap, in_valid, in_last, out_ready;
  logic [1:0]  w_lane;
  logic [7:0]  w_data;
  logic [31:0] in_data;
  logic        in_ready, out_valid, in_ready16, out_valid16;
  logic [23:0] out_acc;
  logic [15:0] out_acc16;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ovf16;

  typedef struct {
    logic [23:0] a24;
    logic [15:0] a16;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pe_mac_lanes dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_lane(w_lane), .w_data(w_data),
    .w_swap(w_swap), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
  );

  pe_mac_lanes #(.ACC_BW(16)) dut16 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_lane(w_lane), .w_data(w_data),
    .w_swap(w_swap), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input int lane, input int val);
    w_load = 1'b1;
    w_lane = 2'(lane);
    w_data = 8'(val);
    tick();
    w_load = 1'b0;
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    load_w(0, a);
    load_w(1, b);
    load_w(2, c);
    load_w(3, d);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
  endtask

  // Present one beat and hold it until accepted; last beats queue their result.
  task automatic beat(input logic [31:0] d, input logic last, input string tag,
                      input int e24, input int e16);
    exp_t e;
    logic ok;
    if (last) begin
      e.a24 = 24'(e24);
      e.a16 = 16'(e16);
      e.tag = tag;
      sb.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout_%s actual=0 required=1", tag);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0d required=none", $signed(out_acc));
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_acc"}, 32'(out_acc), 32'(mon_e.a24));
        chk({mon_e.tag, "_acc16"}, 32'(out_acc16), 32'(mon_e.a16));
        chk({mon_e.tag, "_valid16"}, 32'(out_valid16), 32'd1);
        $display("result %s acc=%0d acc16=%0d", mon_e.tag, $signed(out_acc), $signed(out_acc16));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
`ifdef PE_MAC_SATURATE_EN
    ovf16 = 32767;
`else
    ovf16 = -3060;
`endif
    rst = 1'b1; w_load = 1'b0; w_swap = 1'b0; w_lane = '0; w_data = '0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_out_acc16", 32'(out_acc16), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Weights 1,2,3,4; single last beat gives 10 two cycles after acceptance.
    set_w(1, 2, 3, 4);
    beat(pk(1, 1, 1, 1), 1'b1, "w1234", 10, 10);
    @(negedge clk);
    chk("lat1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat2_out_valid", 32'(out_valid), 32'd1);
    chk("lat2_out_acc", 32'(out_acc), 32'd10);
    tick();

    // Back-to-back single-beat results, one per cycle.
    c0 = cyc;
    beat(pk(1, 0, 0, 0), 1'b1, "tp0", 1, 1);
    beat(pk(2, 0, 0, 1), 1'b1, "tp1", 6, 6);
    beat(pk(0, 0, 1, 0), 1'b1, "tp2", 3, 3);
    beat(pk(-1, -1, -1, -1), 1'b1, "tp3", -10, -10);
    chk("tp_cycles", 32'(cyc - c0), 32'd4);
    repeat (3) tick();

    // Backpressure: results held, input blocked, nothing lost on release.
    out_ready = 1'b0;
    beat(pk(1, 1, 1, 1), 1'b1, "st0", 10, 10);
    beat(pk(2, 2, 2, 2), 1'b1, "st1", 20, 20);
    in_valid = 1'b1;
    in_data  = pk(1, 0, 0, 0);
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_acc", 32'(out_acc), 32'd10);
    end
    tick();
    out_ready = 1'b1;
    beat(pk(1, 0, 0, 0), 1'b1, "st2", 1, 1);
    repeat (4) tick();

    // Multi-beat accumulation with mixed-sign weights: 2 + 4 - 1.
    set_w(-1, 2, -3, 4);
    beat(pk(1, 1, 1, 1), 1'b0, "acc_a", 0, 0);
    beat(pk(2, 2, 2, 2), 1'b0, "acc_b", 0, 0);
    beat(pk(1, 0, 0, 0), 1'b1, "acc3", 5, 5);

    // Load+swap during an accepted beat: old weights now, 7 on lane 2 next.
    w_load = 1'b1; w_lane = 2'd2; w_data = 8'd7; w_swap = 1'b1;
    beat(pk(1, 1, 1, 1), 1'b1, "swap_old", 2, 2);
    w_load = 1'b0; w_swap = 1'b0;
    beat(pk(1, 1, 1, 1), 1'b1, "swap_new", 12, 12);
    repeat (3) tick();

    // 3 x 64516 = 193548: fits 24 bits; wraps or clamps at 16 bits.
    set_w(127, 127, 127, 127);
    beat(pk(127, 127, 127, 127), 1'b0, "ovf_a", 0, 0);
    beat(pk(127, 127, 127, 127), 1'b0, "ovf_b", 0, 0);
    beat(pk(127, 127, 127, 127), 1'b1, "ovf", 193548, ovf16);
    repeat (3) tick();

    // Reset mid-accumulation discards everything, weights return to zero.
    beat(pk(1, 1, 1, 1), 1'b0, "rst_a", 0, 0);
    beat(pk(2, 2, 2, 2), 1'b0, "rst_b", 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_acc", 32'(out_acc), 32'd0);
    chk("post_rst_out_acc16", 32'(out_acc16), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_idle_valid", 32'(out_valid), 32'd0);
    end
    tick();
    beat(pk(1, 1, 1, 1), 1'b1, "rst_zero_w", 0, 0);
    repeat (5) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
